// File: rtl/nanop_core.sv
// Nanoprocessor core: PC, fetch/execute sequencer, accumulator ALU and flags in one block.
// Each instruction is two words (opcode, operand address) and takes four clock cycles.
module nanop_core #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              instr_done,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              flag_c,
    output logic              flag_z
);

    typedef enum logic [1:0] {FETCH_I, FETCH_A, FETCH_D, EXEC} state_t;

    typedef enum logic [3:0] {
        OP_NOP, OP_XOR, OP_AND, OP_OR,  OP_ADD, OP_ADC, OP_SUB, OP_SBC,
        OP_ROL, OP_ROR, OP_LDA, OP_STA, OP_OUT, OP_JMP, OP_JNC, OP_JNZ
    } opcode_t;

    state_t            state;
    opcode_t           ir;
    logic [ADDR_W-1:0] ad;
    logic [ADDR_W-1:0] pc_inc1;
    logic [ADDR_W-1:0] pc_inc2;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] alu_acc;
    logic              alu_c;
    logic              upd_acc;
    logic              take_jump;

    assign pc_inc1   = pc + ADDR_W'(1);
    assign pc_inc2   = pc + ADDR_W'(2);
    assign mem_wdata = acc;
    // Gating with reset keeps an aborted STA from reaching memory on the reset edge.
    assign mem_we    = (state == EXEC) && (ir == OP_STA) && !reset;
    assign take_jump = (ir == OP_JMP) || ((ir == OP_JNC) && !flag_c) ||
                       ((ir == OP_JNZ) && !flag_z);

    // In FETCH_D the operand address is taken straight off the bus so M arrives in EXEC.
    always_comb begin
        case (state)
            FETCH_I: mem_addr = pc;
            FETCH_A: mem_addr = pc_inc1;
            FETCH_D: mem_addr = mem_rdata[ADDR_W-1:0];
            default: mem_addr = ad;
        endcase
    end

    always_comb begin
        alu_acc = acc;
        alu_c   = flag_c;
        upd_acc = 1'b0;
        sum     = '0;
        case (ir)
            OP_XOR: begin alu_acc = acc ^ mem_rdata; upd_acc = 1'b1; end
            OP_AND: begin alu_acc = acc & mem_rdata; upd_acc = 1'b1; end
            OP_OR:  begin alu_acc = acc | mem_rdata; upd_acc = 1'b1; end
            OP_ADD: begin
                sum = {1'b0, acc} + {1'b0, mem_rdata};
                {alu_c, alu_acc} = sum;
                upd_acc = 1'b1;
            end
            OP_ADC: begin
                sum = {1'b0, acc} + {1'b0, mem_rdata} + {{DATA_W{1'b0}}, flag_c};
                {alu_c, alu_acc} = sum;
                upd_acc = 1'b1;
            end
            OP_SUB: begin
                sum = {1'b0, acc} - {1'b0, mem_rdata};
                {alu_c, alu_acc} = sum;
                upd_acc = 1'b1;
            end
            OP_SBC: begin
                sum = {1'b0, acc} - {1'b0, mem_rdata} - {{DATA_W{1'b0}}, flag_c};
                {alu_c, alu_acc} = sum;
                upd_acc = 1'b1;
            end
            OP_ROL: begin {alu_c, alu_acc} = {acc, flag_c}; upd_acc = 1'b1; end
            OP_ROR: begin {alu_acc, alu_c} = {flag_c, acc}; upd_acc = 1'b1; end
            OP_LDA: begin alu_acc = mem_rdata; upd_acc = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_I;
            pc         <= RESET_PC;
            acc        <= '0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            instr_done <= 1'b0;
            ir         <= OP_NOP;
            ad         <= '0;
        end else begin
            out_valid  <= 1'b0;
            instr_done <= 1'b0;
            case (state)
                FETCH_I: if (run) state <= FETCH_A;
                FETCH_A: begin
                    ir    <= opcode_t'(mem_rdata[3:0]);
                    state <= FETCH_D;
                end
                FETCH_D: begin
                    ad    <= mem_rdata[ADDR_W-1:0];
                    state <= EXEC;
                end
                EXEC: begin
                    if (upd_acc) begin
                        acc    <= alu_acc;
                        flag_c <= alu_c;
                        flag_z <= (alu_acc == '0);
                    end
                    if (ir == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                    pc         <= take_jump ? ad : pc_inc2;
                    instr_done <= 1'b1;
                    state      <= FETCH_I;
                end
            endcase
        end
    end

endmodule

// File: doc/nanop_core.md
Name: nanop_core

Overview:
- Parametrised nanoprocessor core. It merges program counter, fetch/execute controller, accumulator ALU and flag register into one sequential block.
- Supports the full 16-opcode nanoprocessor set, including carry arithmetic, rotates, output and conditional jumps.
- Talks to a single synchronous program/data memory.
- Sits between that memory and the board output register.

Parameters:
DATA_W, 8, data/instruction word width (>= 4)
ADDR_W, 8, memory address width (1 <= ADDR_W <= DATA_W)
RESET_PC, 0, PC value loaded at reset (ADDR_W bits)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous reset, active-high
run  input  1  1 = execute; 0 = hold at next instruction boundary
mem_addr  output  ADDR_W  memory address (combinational from state/regs)
mem_rdata  input  DATA_W  memory read data, valid 1 cycle after address
mem_wdata  output  DATA_W  write data (= ACC)
mem_we  output  1  write strobe, one cycle
out_data  output  DATA_W  last value emitted by OUT
out_valid  output  1  one-cycle pulse when out_data updated
instr_done  output  1  one-cycle pulse after each executed instruction
pc  output  ADDR_W  current PC
acc  output  DATA_W  accumulator
flag_c  output  1  carry/borrow flag
flag_z  output  1  zero flag

Behaviour:
- Reset (synchronous, clk edge with reset=1, overrides everything in any state):
  - PC=RESET_PC; ACC=0; C=0; Z=0; state=FETCH_I.
  - out_data=0; out_valid=0; instr_done=0; mem_we=0.
  - A reset mid-instruction aborts it with no write.
- Instruction format: two words.
  - Word at PC: opcode = bits[3:0]; upper bits are ignored.
  - Word at PC+1: operand address AD = bits[ADDR_W-1:0].
  - M = word read at AD.
- FSM, 4 cycles per instruction:
  - FETCH_I: mem_addr=PC. If run=1 go to FETCH_A; otherwise stay (stall only here).
  - FETCH_A: IR<=mem_rdata; mem_addr=PC+1; go to FETCH_D.
  - FETCH_D: AD<=mem_rdata; mem_addr=AD; go to EXEC.
  - EXEC: M=mem_rdata; mem_addr=AD; execute opcode; update PC; go to FETCH_I.
- Opcodes (all arithmetic mod 2^DATA_W):
  - NOP 0: no register changes.
  - XOR 1, AND 2, OR 3: ACC op= M. Z updated; C unchanged.
  - ADD 4: {C,ACC}=ACC+M. ADC 5: {C,ACC}=ACC+M+C.
  - SUB 6: ACC=ACC-M, C=1 iff borrow (ACC<M). SBC 7: ACC=ACC-M-C, C=borrow. Z updated for 4-7.
  - ROL 8: {C,ACC}={ACC,C} (rotate left through carry). ROR 9: {ACC,C}={C,ACC}. Z updated; M ignored.
  - LDA A: ACC=M; Z updated; C unchanged.
  - STA B: mem_we=1 during EXEC; mem_wdata=ACC; mem_addr=AD; flags unchanged.
  - OUT C: out_data<=ACC; out_valid=1 in the cycle after EXEC.
  - JMP D: PC=AD. JNC E: PC=AD if C=0. JNZ F: PC=AD if Z=0. Flags unchanged.
- Z always reflects the new ACC value when updated.
- PC:
  - Non-taken instructions: PC=PC+2 mod 2^ADDR_W (0xFE -> 0x00 at ADDR_W=8).
  - PC+1 fetch address also wraps (0xFF -> 0x00).
- instr_done is high exactly one cycle after every EXEC, including STA, NOP and jumps. out_valid is high only after OUT.
- mem_we is 0 in all states except EXEC with STA.
- run is sampled only in FETCH_I. run=0 mid-instruction does not stop the instruction; the core halts at the following FETCH_I with mem_addr=PC.
- ADDR_W<DATA_W: operand address uses the low ADDR_W bits only.

Test Plan:
- Reset/idle: reset=1 for 2 cycles then run=0 for 10 cycles -> pc=0, acc=0, flags 0, mem_we=0, mem_addr=0, no pulses.
- Load/add with carry: mem[0..3]={0A,10,04,11}, mem[10]=F0, mem[11]=20, run=1 -> after 8 cycles acc=10, C=1, Z=0, pc=04; instr_done pulses twice.
- Carry chain and subtract: ACC=FF C=0 + ADC of M=01 -> acc=00, C=1, Z=1. Then SBC M=00 -> acc=FF, C=1 (borrow), Z=0.
- STA/OUT/rotate: ACC=81, C=0. ROL -> acc=02, C=1. STA 20 -> mem_we single cycle, addr 20, wdata 02. OUT -> out_data=02, out_valid one cycle.
- Branching and wrap: JNZ 40 with Z=0 -> pc=40; with Z=1 -> pc+2. JNC 40 with C=1 -> not taken. Instruction at PC=FE -> next pc=00 and PC+1 fetch at FF.
- Reset mid-EXEC of STA and run drop during FETCH_D:
  - Reset: no write; state resumes at FETCH_I with pc=RESET_PC.
  - run drop: instruction completes, then core holds at FETCH_I.
  - Rerun with DATA_W=16, ADDR_W=10: add wraps at 16 bits; pc wraps 3FE -> 000.
